mem_stage: RTL and testbench
============================

# mem_stage

Memory stage of the 5-stage MIPS pipeline. It holds the EX/MEM pipeline register, the word-addressed data memory, branch resolution and the MEM/WB pipeline register. It consumes the execute stage's ALU result, store operand, destination register, zero flag and branch target. It produces the two forwarding sources the execute stage muxes between: the EX/MEM ALU result and the MEM/WB write-back value.

## Interface
- DEPTH_LOG2, 8, log2 of data-memory depth in 32-bit words (default 256 words, 1 KiB)
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- stall  in  1  hold EX/MEM contents; bubble into MEM/WB
- flush  in  1  load a bubble into EX/MEM
- ex_alu_result  in  32  ALU result / memory byte address
- ex_store_data  in  32  forwarded rt value (store data)
- ex_reg_dest  in  5  write-back register number
- ex_zero  in  1  ALU zero flag
- ex_branch_addr  in  32  computed branch target
- ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch  in  1 each  control bits from ID/EX
- exmem_alu_result  out  32  EX/MEM ALU result (forwarding source, ForwardX=2)
- exmem_reg_dest  out  5  EX/MEM destination (forwarding unit)
- exmem_reg_write  out  1  EX/MEM write enable (forwarding unit)
- pc_src  out  1  branch taken
- branch_target  out  32  EX/MEM branch address
- wb_data  out  32  MEM/WB selected write-back data (forwarding source, ForwardX=1)
- wb_reg_dest  out  5  MEM/WB destination
- wb_reg_write  out  1  MEM/WB write enable
- misalign_err  out  1  sticky misaligned-access flag (see Configuration)

## Operation
- EX/MEM register captures every ex_* input on each edge unless stall=1.
- Bubble means all five control bits are 0. Data fields in a bubble are don't-care but are loaded with the inputs.
- Memory word index is addr[DEPTH_LOG2+1:2]. Address bits above the index are ignored, so addresses wrap modulo the memory size.
- Memory read is combinational from the EX/MEM address.
- Memory write occurs at the rising edge ending the MEM cycle, only when exmem mem_write=1 and stall=0. It writes exmem store data.
- Memory contents are not reset and are X until written.
- pc_src = exmem branch AND exmem zero. branch_target = exmem branch address. Both are combinational from EX/MEM.
- MEM/WB captures the following:
  - reg_write and reg_dest.
  - wb_data: the memory read data if exmem mem_to_reg=1, otherwise the exmem ALU result.
- One instruction occupies MEM per cycle, so a same-address read and write in one cycle is impossible.

## Timing
- Reset (rst_n=0 at an edge): all EX/MEM and MEM/WB registers clear to 0. Every output reads 0 on the following cycle (pc_src=0, wb_reg_write=0, misalign_err=0).
- Reset overrides stall and flush. Memory is untouched by reset.
- Latency:
  - An input presented in cycle N appears on the exmem_* outputs, pc_src and branch_target in cycle N+1.
  - wb_* outputs follow in cycle N+2.
- flush=1: EX/MEM loads a bubble. Flush has priority over stall.
- stall=1 (flush=0):
  - EX/MEM holds its value and the memory write is suppressed.
  - MEM/WB loads a bubble (wb_reg_write=0).
  - The held instruction completes on the first edge where stall=0.
- Back-to-back load then dependent use: the load value is visible on wb_data in cycle N+2. Inserting the required stall is the hazard unit's job, not this block's.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - An access with exmem mem_read or mem_write set and address[1:0]≠0 is misaligned.
  - A misaligned store suppresses its memory write.
  - A misaligned load sets MEM/WB reg_write to 0.
  - misalign_err is set on the capturing edge and stays set until reset.
- MEM_ALIGN_CHECK_EN undefined: address[1:0] are ignored and accesses are word-aligned by truncation. misalign_err is tied to 0.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with all inputs randomized → all outputs 0 and pc_src=0. Stored data is unchanged after reset.
- Store/load: sw of 0xDEADBEEF to address 0x10, then lw from 0x10 with mem_to_reg=1 and reg_dest=5 → wb_data=0xDEADBEEF, wb_reg_dest=5, wb_reg_write=1, two cycles after the lw is presented.
- Wrap: with DEPTH_LOG2=8, sw of 0x12345678 to 0x400, then lw from 0x000 → wb_data=0x12345678.
- Branch: ex_branch=1, ex_zero=1, ex_branch_addr=0x40 → pc_src=1 and branch_target=0x40 next cycle. The same with ex_zero=0 → pc_src=0.
- Stall/flush:
  - A sw held by stall=1 for 3 cycles writes exactly once, after release, and wb_reg_write=0 during the stall.
  - Asserting flush together with stall and an ALU op (reg_write=1) → EX/MEM is a bubble and exmem_reg_write=0.
- Align (MEM_ALIGN_CHECK_EN defined): sw to 0x11 → memory word 4 is unchanged and misalign_err=1, and it stays 1 until rst_n=0.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of a 5-stage MIPS pipeline.
// Contains the EX/MEM register, word-addressed data memory, branch resolution
// and the MEM/WB register. Optional alignment checking: MEM_ALIGN_CHECK_EN.
module mem_stage #(
   parameter int unsigned DEPTH_LOG2 = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] ex_alu_result,
   input  logic [31:0] ex_store_data,
   input  logic [4:0]  ex_reg_dest,
   input  logic        ex_zero,
   input  logic [31:0] ex_branch_addr,
   input  logic        ex_reg_write,
   input  logic        ex_mem_to_reg,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic        ex_branch,
   output logic [31:0] exmem_alu_result,
   output logic [4:0]  exmem_reg_dest,
   output logic        exmem_reg_write,
   output logic        pc_src,
   output logic [31:0] branch_target,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_reg_dest,
   output logic        wb_reg_write,
   output logic        misalign_err
);

   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
      logic mem_read;
      logic mem_write;
      logic branch;
   } ctrl_t;

   typedef struct packed {
      ctrl_t       ctrl;
      logic [31:0] alu_result;
      logic [31:0] store_data;
      logic [31:0] branch_addr;
      logic [4:0]  reg_dest;
      logic        zero;
   } exmem_t;

   typedef struct packed {
      logic        reg_write;
      logic [4:0]  reg_dest;
      logic [31:0] data;
   } memwb_t;

   exmem_t      ex_in;
   exmem_t      exmem_d, exmem_q;
   memwb_t      memwb_d, memwb_q;
   logic        misalign_err_d, misalign_err_q;

   logic [31:0]           mem [DEPTH];
   logic [DEPTH_LOG2-1:0] mem_idx;
   logic [31:0]           mem_rdata;
   logic                  misaligned;
   logic                  mem_we;

   // Gather the execute-stage inputs into one EX/MEM payload
   always_comb begin
      ex_in                 = '0;
      ex_in.ctrl.reg_write  = ex_reg_write;
      ex_in.ctrl.mem_to_reg = ex_mem_to_reg;
      ex_in.ctrl.mem_read   = ex_mem_read;
      ex_in.ctrl.mem_write  = ex_mem_write;
      ex_in.ctrl.branch     = ex_branch;
      ex_in.alu_result      = ex_alu_result;
      ex_in.store_data      = ex_store_data;
      ex_in.branch_addr     = ex_branch_addr;
      ex_in.reg_dest        = ex_reg_dest;
      ex_in.zero            = ex_zero;
   end

   // EX/MEM next state: flush loads a bubble and wins over stall, which holds
   always_comb begin
      exmem_d = exmem_q;
      if (flush) begin
         exmem_d      = ex_in;
         exmem_d.ctrl = '0;
      end else if (!stall) begin
         exmem_d = ex_in;
      end
   end

   // Word index; address bits above it are dropped so accesses wrap
   assign mem_idx   = exmem_q.alu_result[DEPTH_LOG2+1:2];
   assign mem_rdata = mem[mem_idx];

`ifdef MEM_ALIGN_CHECK_EN
   assign misaligned = (exmem_q.alu_result[1:0] != 2'b00) &&
                       (exmem_q.ctrl.mem_read || exmem_q.ctrl.mem_write);
`else
   assign misaligned = 1'b0;
`endif

   // Stores retire at the edge ending MEM; reset never touches the array
   assign mem_we = rst_n && exmem_q.ctrl.mem_write && !stall && !misaligned;

   // Data memory write port (no reset: contents persist)
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_idx] <= exmem_q.store_data;
      end
   end

   // MEM/WB next state: stall bubbles write-back, misaligned loads never write
   always_comb begin
      memwb_d           = '0;
      memwb_d.reg_write = exmem_q.ctrl.reg_write && !stall &&
                          !(misaligned && exmem_q.ctrl.mem_read);
      memwb_d.reg_dest  = exmem_q.reg_dest;
      memwb_d.data      = exmem_q.ctrl.mem_to_reg ? mem_rdata : exmem_q.alu_result;
      misalign_err_d    = misalign_err_q || (misaligned && !stall);
   end

   // Pipeline registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         exmem_q        <= '0;
         memwb_q        <= '0;
         misalign_err_q <= 1'b0;
      end else begin
         exmem_q        <= exmem_d;
         memwb_q        <= memwb_d;
         misalign_err_q <= misalign_err_d;
      end
   end

   assign exmem_alu_result = exmem_q.alu_result;
   assign exmem_reg_dest   = exmem_q.reg_dest;
   assign exmem_reg_write  = exmem_q.ctrl.reg_write;
   assign pc_src           = exmem_q.ctrl.branch && exmem_q.zero;
   assign branch_target    = exmem_q.branch_addr;
   assign wb_data          = memwb_q.data;
   assign wb_reg_dest      = memwb_q.reg_dest;
   assign wb_reg_write     = memwb_q.reg_write;
   assign misalign_err     = misalign_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage (default DEPTH_LOG2 = 8).
// Honours MEM_ALIGN_CHECK_EN in its reference model.
module tb_mem_stage;

   localparam int unsigned DL = 8;

   logic        clk = 1'b0;
   logic        rst_n, stall, flush;
   logic [31:0] ex_alu_result, ex_store_data, ex_branch_addr;
   logic [4:0]  ex_reg_dest;
   logic        ex_zero, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch;
   logic [31:0] exmem_alu_result, branch_target, wb_data;
   logic [4:0]  exmem_reg_dest, wb_reg_dest;
   logic        exmem_reg_write, pc_src, wb_reg_write, misalign_err;

   typedef struct packed {
      logic        we;
      logic [4:0]  dest;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mdl [256];
   bit          known [256];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   mem_stage #(.DEPTH_LOG2(DL)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
      .ex_reg_dest(ex_reg_dest), .ex_zero(ex_zero), .ex_branch_addr(ex_branch_addr),
      .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
      .exmem_alu_result(exmem_alu_result), .exmem_reg_dest(exmem_reg_dest),
      .exmem_reg_write(exmem_reg_write), .pc_src(pc_src), .branch_target(branch_target),
      .wb_data(wb_data), .wb_reg_dest(wb_reg_dest), .wb_reg_write(wb_reg_write),
      .misalign_err(misalign_err)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] dest,
                         input logic zero, input logic [31:0] baddr, input logic rw,
                         input logic m2r, input logic mr, input logic mw, input logic br);
      ex_alu_result  = alu;
      ex_store_data  = sd;
      ex_reg_dest    = dest;
      ex_zero        = zero;
      ex_branch_addr = baddr;
      ex_reg_write   = rw;
      ex_mem_to_reg  = m2r;
      ex_mem_read    = mr;
      ex_mem_write   = mw;
      ex_branch      = br;
   endtask

   task automatic bubble;
      set_in(32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Reference model: expected write-back for one instruction, updating model memory
   task automatic issue(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] dest,
                        input logic rw, input logic m2r, input logic mr, input logic mw);
      exp_t       e;
      logic [7:0] idx;
      logic       mis;
      set_in(alu, sd, dest, 1'b0, 32'h0, rw, m2r, mr, mw, 1'b0);
      idx = alu[DL+1:2];
`ifdef MEM_ALIGN_CHECK_EN
      mis = (alu[1:0] != 2'b00) && (mr || mw);
`else
      mis = 1'b0;
`endif
      e.we   = rw && !(mis && mr);
      e.dest = dest;
      e.data = m2r ? mdl[idx] : alu;
      if (mw && !mis) begin
         mdl[idx]   = sd;
         known[idx] = 1'b1;
      end
      exp_q.push_back(e);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) begin
         set_in($urandom, $urandom, 5'($urandom), 1'($urandom), $urandom, 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         stall = 1'($urandom);
         flush = 1'($urandom);
         tick();
      end
      checks++; if (exmem_alu_result !== 32'h0) begin errors++; $display("FAIL rst_exmem_alu got %h exp 0", exmem_alu_result); end
      checks++; if (exmem_reg_dest !== 5'h0) begin errors++; $display("FAIL rst_exmem_rd got %0d exp 0", exmem_reg_dest); end
      checks++; if (exmem_reg_write !== 1'b0) begin errors++; $display("FAIL rst_exmem_rw got %b exp 0", exmem_reg_write); end
      checks++; if (pc_src !== 1'b0) begin errors++; $display("FAIL rst_pc_src got %b exp 0", pc_src); end
      checks++; if (branch_target !== 32'h0) begin errors++; $display("FAIL rst_btarget got %h exp 0", branch_target); end
      checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL rst_wb_data got %h exp 0", wb_data); end
      checks++; if (wb_reg_dest !== 5'h0) begin errors++; $display("FAIL rst_wb_rd got %0d exp 0", wb_reg_dest); end
      checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL rst_wb_rw got %b exp 0", wb_reg_write); end
      checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL rst_misalign got %b exp 0", misalign_err); end
      rst_n = 1'b1;
      stall = 1'b0;
      flush = 1'b0;
      bubble();
      tick();
   endtask

   task automatic test_store_load;
      logic [31:0] tab_alu  [5] = '{32'h10, 32'h10, 32'h400, 32'h000, 32'h77};
      logic [31:0] tab_sd   [5] = '{32'hDEADBEEF, 32'h0, 32'h12345678, 32'h0, 32'h0};
      logic [4:0]  tab_rd   [5] = '{5'd0, 5'd5, 5'd0, 5'd6, 5'd3};
      logic [3:0]  tab_ctl  [5] = '{4'b0001, 4'b1110, 4'b0001, 4'b1110, 4'b1000};
      exp_t e;
      for (int i = 0; i < 5; i++) begin
         issue(tab_alu[i], tab_sd[i], tab_rd[i], tab_ctl[i][3], tab_ctl[i][2], tab_ctl[i][1], tab_ctl[i][0]);
         tick();
         if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            checks++;
            if ({wb_reg_write, wb_reg_dest, wb_data} !== {e.we, e.dest, e.data}) begin
               errors++;
               $display("FAIL store_load_wb[%0d] got we=%b rd=%0d data=%h exp we=%b rd=%0d data=%h",
                        i, wb_reg_write, wb_reg_dest, wb_data, e.we, e.dest, e.data);
            end
         end
      end
      bubble();
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({wb_reg_write, wb_reg_dest, wb_data} !== {e.we, e.dest, e.data}) begin
         errors++;
         $display("FAIL store_load_drain got we=%b rd=%0d data=%h exp we=%b rd=%0d data=%h",
                  wb_reg_write, wb_reg_dest, wb_data, e.we, e.dest, e.data);
      end
   endtask

   task automatic test_branch;
      set_in(32'h0, 32'h0, 5'd0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      checks++; if (pc_src !== 1'b1) begin errors++; $display("FAIL br_taken got %b exp 1", pc_src); end
      checks++; if (branch_target !== 32'h40) begin errors++; $display("FAIL br_target got %h exp 40", branch_target); end
      set_in(32'h1, 32'h0, 5'd0, 1'b0, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      checks++; if (pc_src !== 1'b0) begin errors++; $display("FAIL br_not_zero got %b exp 0", pc_src); end
      checks++; if (branch_target !== 32'h80) begin errors++; $display("FAIL br_target2 got %h exp 80", branch_target); end
      set_in(32'h0, 32'h0, 5'd0, 1'b1, 32'hC0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checks++; if (pc_src !== 1'b0) begin errors++; $display("FAIL br_no_branch got %b exp 0", pc_src); end
      bubble();
      tick();
   endtask

   task automatic test_stall;
      exp_t e;
      issue(32'h20, 32'h55AA33CC, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      stall = 1'b1;
      set_in(32'h20, 32'h0, 5'd7, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (wb_reg_write !== 1'b0 || exmem_alu_result !== 32'h20 || exmem_reg_write !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold[%0d] got wb_rw=%b exmem_alu=%h exmem_rw=%b exp 0/20/0",
                     i, wb_reg_write, exmem_alu_result, exmem_reg_write);
         end
      end
      stall = 1'b0;
      issue(32'h20, 32'h0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      for (int i = 0; i < 2; i++) begin
         e = exp_q.pop_front();
         checks++;
         if ({wb_reg_write, wb_reg_dest, wb_data} !== {e.we, e.dest, e.data}) begin
            errors++;
            $display("FAIL stall_wb[%0d] got we=%b rd=%0d data=%h exp we=%b rd=%0d data=%h",
                     i, wb_reg_write, wb_reg_dest, wb_data, e.we, e.dest, e.data);
         end
         bubble();
         tick();
      end
   endtask

   task automatic test_flush;
      exp_t e;
      stall = 1'b1;
      flush = 1'b1;
      set_in(32'h99, 32'h0, 5'd9, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checks++; if (exmem_reg_write !== 1'b0) begin errors++; $display("FAIL flush_stall_rw got %b exp 0", exmem_reg_write); end
      checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL flush_stall_wb got %b exp 0", wb_reg_write); end
      stall = 1'b0;
      set_in(32'h10, 32'h0BADBAD0, 5'd0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      checks++; if (exmem_reg_write !== 1'b0 || pc_src !== 1'b0) begin
         errors++; $display("FAIL flush_bubble got rw=%b pc_src=%b exp 0/0", exmem_reg_write, pc_src);
      end
      flush = 1'b0;
      issue(32'h10, 32'h0, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      bubble();
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({wb_reg_write, wb_reg_dest, wb_data} !== {e.we, e.dest, e.data}) begin
         errors++;
         $display("FAIL flush_no_store got we=%b rd=%0d data=%h exp we=%b rd=%0d data=%h",
                  wb_reg_write, wb_reg_dest, wb_data, e.we, e.dest, e.data);
      end
   endtask

   task automatic test_back_to_back;
      exp_t        e;
      logic [7:0]  idx;
      int          kind;
      for (int i = 0; i < 24; i++) begin
         idx  = 8'(64 + $urandom_range(0, 15));
         kind = (i < 2) ? 0 : int'($urandom_range(0, 2));
         if (kind == 1 && !known[idx]) kind = 0;
         case (kind)
            0: issue({22'h0, idx, 2'b00}, $urandom, 5'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
            1: issue({22'h0, idx, 2'b00}, $urandom, 5'($urandom_range(1, 31)), 1'b1, 1'b1, 1'b1, 1'b0);
            default: issue($urandom, $urandom, 5'($urandom_range(1, 31)), 1'b1, 1'b0, 1'b0, 1'b0);
         endcase
         tick();
         if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            checks++;
            if ({wb_reg_write, wb_reg_dest, wb_data} !== {e.we, e.dest, e.data}) begin
               errors++;
               $display("FAIL b2b_wb[%0d] got we=%b rd=%0d data=%h exp we=%b rd=%0d data=%h",
                        i, wb_reg_write, wb_reg_dest, wb_data, e.we, e.dest, e.data);
            end
         end
      end
      bubble();
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({wb_reg_write, wb_reg_dest, wb_data} !== {e.we, e.dest, e.data}) begin
         errors++;
         $display("FAIL b2b_drain got we=%b rd=%0d data=%h exp we=%b rd=%0d data=%h",
                  wb_reg_write, wb_reg_dest, wb_data, e.we, e.dest, e.data);
      end
   endtask

   task automatic test_reset_keep;
      exp_t e;
      issue(32'h30, 32'hCAFEF00D, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      bubble();
      tick();
      void'(exp_q.pop_front());
      rst_n = 1'b0;
      repeat (2) begin
         set_in($urandom, $urandom, 5'($urandom), 1'($urandom), $urandom, 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         stall = 1'($urandom);
         flush = 1'($urandom);
         tick();
      end
      checks++; if (wb_reg_write !== 1'b0 || exmem_reg_write !== 1'b0 || pc_src !== 1'b0) begin
         errors++; $display("FAIL rst2_ctrl got wb_rw=%b exmem_rw=%b pc_src=%b exp 0", wb_reg_write, exmem_reg_write, pc_src);
      end
      rst_n = 1'b1;
      stall = 1'b0;
      flush = 1'b0;
      issue(32'h30, 32'h0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      bubble();
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({wb_reg_write, wb_reg_dest, wb_data} !== {e.we, e.dest, e.data}) begin
         errors++;
         $display("FAIL rst_keep_mem got we=%b rd=%0d data=%h exp we=%b rd=%0d data=%h",
                  wb_reg_write, wb_reg_dest, wb_data, e.we, e.dest, e.data);
      end
   endtask

   task automatic test_align;
      exp_t e;
      logic exp_err;
`ifdef MEM_ALIGN_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      issue(32'h11, 32'hBAD0BAD0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      issue(32'h10, 32'h0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         if (i == 0) issue(32'h12, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
         else bubble();
         e = exp_q.pop_front();
         checks++;
         if ({wb_reg_write, wb_reg_dest, wb_data} !== {e.we, e.dest, e.data}) begin
            errors++;
            $display("FAIL align_wb[%0d] got we=%b rd=%0d data=%h exp we=%b rd=%0d data=%h",
                     i, wb_reg_write, wb_reg_dest, wb_data, e.we, e.dest, e.data);
         end
         tick();
      end
      repeat (3) tick();
      checks++; if (misalign_err !== exp_err) begin errors++; $display("FAIL align_sticky got %b exp %b", misalign_err, exp_err); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL align_reset got %b exp 0", misalign_err); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) known[i] = 1'b0;
      rst_n = 1'b0;
      stall = 1'b0;
      flush = 1'b0;
      bubble();
      test_reset();
      test_store_load();
      test_branch();
      test_stall();
      test_flush();
      test_back_to_back();
      test_reset_keep();
      test_align();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
